// File: rtl/flip_sequencer.sv
// flip_sequencer: validates and commits one Reversi move on an 8x8 board RAM.
// Ports: clk/resetn, start+move_row/col+whiteOrBlack request,
//   rd_addr/rd_data board read (1-cycle sync RAM), wr_en/wr_addr/wr_data
//   board write, busy, next_turn/illegal done pulses, flip_count result.
// Build option FLIPSEQ_PROBE_EN adds input probe and output legal.
//   A probe move scans without writing and reports legal/illegal.
module flip_sequencer #(
  parameter logic [1:0] EMPTY_CODE = 2'b00,
  parameter logic [1:0] BLACK_CODE = 2'b01,
  parameter logic [1:0] WHITE_CODE = 2'b10
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [2:0] move_row,
  input  logic [2:0] move_col,
  input  logic       whiteOrBlack,
`ifdef FLIPSEQ_PROBE_EN
  input  logic       probe,
  output logic       legal,
`endif
  output logic [5:0] rd_addr,
  input  logic [1:0] rd_data,
  output logic       wr_en,
  output logic [5:0] wr_addr,
  output logic [1:0] wr_data,
  output logic       busy,
  output logic       next_turn,
  output logic       illegal,
  output logic [4:0] flip_count
);

  typedef enum logic [3:0] {
    IDLE,
    ORG_RD,
    ORG_CHK,
    DIR_INIT,
    SCAN_RD,
    SCAN_CHK,
    FLIP,
    NEXT_DIR,
    PLACE,
    DONE_OK,
    DONE_BAD
  } state_t;

  state_t state_q, state_d;

  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  logic       white_q, white_d;
  logic [2:0] dir_q, dir_d;
  logic [2:0] run_q, run_d;
  logic [4:0] count_q, count_d;
  logic [4:0] fcnt_q, fcnt_d;

  // Cursor is signed 4-bit so one step past either edge is
  // visible as bit 3 set (-1 -> 4'b1111, 8 -> 4'b1000).
  logic signed [3:0] cur_r_q, cur_r_d;
  logic signed [3:0] cur_c_q, cur_c_d;

  logic probe_mode;

`ifdef FLIPSEQ_PROBE_EN
  logic probe_q, probe_d;
  assign probe_mode = probe_q;
`else
  assign probe_mode = 1'b0;
`endif

  logic signed [3:0] dr;
  logic signed [3:0] dc;

  // Direction order N, NE, E, SE, S, SW, W, NW.
  always_comb begin
    dr = 4'sd0;
    dc = 4'sd0;
    unique case (dir_q)
      3'd0: begin dr = -4'sd1; dc =  4'sd0; end
      3'd1: begin dr = -4'sd1; dc =  4'sd1; end
      3'd2: begin dr =  4'sd0; dc =  4'sd1; end
      3'd3: begin dr =  4'sd1; dc =  4'sd1; end
      3'd4: begin dr =  4'sd1; dc =  4'sd0; end
      3'd5: begin dr =  4'sd1; dc = -4'sd1; end
      3'd6: begin dr =  4'sd0; dc = -4'sd1; end
      3'd7: begin dr = -4'sd1; dc = -4'sd1; end
      default: begin dr = 4'sd0; dc = 4'sd0; end
    endcase
  end

  logic signed [3:0] org_r;
  logic signed [3:0] org_c;
  logic signed [3:0] init_r;
  logic signed [3:0] init_c;
  logic signed [3:0] fwd_r;
  logic signed [3:0] fwd_c;
  logic signed [3:0] back_r;
  logic signed [3:0] back_c;
  logic              init_off;
  logic              fwd_off;

  assign org_r  = $signed({1'b0, row_q});
  assign org_c  = $signed({1'b0, col_q});
  assign init_r = org_r + dr;
  assign init_c = org_c + dc;
  assign fwd_r  = cur_r_q + dr;
  assign fwd_c  = cur_c_q + dc;
  assign back_r = cur_r_q - dr;
  assign back_c = cur_c_q - dc;

  assign init_off = init_r[3] | init_c[3];
  assign fwd_off  = fwd_r[3] | fwd_c[3];

  logic [1:0] own_code;
  logic [1:0] opp_code;

  assign own_code = white_q ? WHITE_CODE : BLACK_CODE;
  assign opp_code = white_q ? BLACK_CODE : WHITE_CODE;

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    white_d = white_q;
    dir_d   = dir_q;
    run_d   = run_q;
    count_d = count_q;
    fcnt_d  = fcnt_q;
    cur_r_d = cur_r_q;
    cur_c_d = cur_c_q;
`ifdef FLIPSEQ_PROBE_EN
    probe_d = probe_q;
    legal   = 1'b0;
`endif
    rd_addr    = 6'd0;
    wr_en      = 1'b0;
    wr_addr    = 6'd0;
    wr_data    = EMPTY_CODE;
    next_turn  = 1'b0;
    illegal    = 1'b0;
    flip_count = fcnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          row_d   = move_row;
          col_d   = move_col;
          white_d = whiteOrBlack;
`ifdef FLIPSEQ_PROBE_EN
          probe_d = probe;
`endif
          count_d = 5'd0;
          state_d = ORG_RD;
        end
      end

      ORG_RD: begin
        rd_addr = {row_q, col_q};
        state_d = ORG_CHK;
      end

      ORG_CHK: begin
        if (rd_data != EMPTY_CODE) begin
          state_d = DONE_BAD;
        end else begin
          dir_d   = 3'd0;
          state_d = DIR_INIT;
        end
      end

      DIR_INIT: begin
        cur_r_d = init_r;
        cur_c_d = init_c;
        run_d   = 3'd0;
        state_d = init_off ? NEXT_DIR : SCAN_RD;
      end

      SCAN_RD: begin
        rd_addr = {cur_r_q[2:0], cur_c_q[2:0]};
        state_d = SCAN_CHK;
      end

      SCAN_CHK: begin
        if (rd_data == opp_code) begin
          run_d   = run_q + 3'd1;
          cur_r_d = fwd_r;
          cur_c_d = fwd_c;
          state_d = fwd_off ? NEXT_DIR : SCAN_RD;
        end else if (rd_data == own_code && run_q != 3'd0) begin
          state_d = FLIP;
        end else begin
          state_d = NEXT_DIR;
        end
      end

      // Cursor sits on the bracketing disc; walk back one
      // square per cycle, writing each captured disc.
      FLIP: begin
        if (!probe_mode) begin
          wr_en   = 1'b1;
          wr_addr = {back_r[2:0], back_c[2:0]};
          wr_data = own_code;
        end
        cur_r_d = back_r;
        cur_c_d = back_c;
        run_d   = run_q - 3'd1;
        count_d = count_q + 5'd1;
        if (run_q == 3'd1) begin
          state_d = NEXT_DIR;
        end
      end

      NEXT_DIR: begin
        if (dir_q == 3'd7) begin
          state_d = PLACE;
        end else begin
          dir_d   = dir_q + 3'd1;
          state_d = DIR_INIT;
        end
      end

      PLACE: begin
        if (count_q == 5'd0) begin
          state_d = DONE_BAD;
        end else begin
          if (!probe_mode) begin
            wr_en   = 1'b1;
            wr_addr = {row_q, col_q};
            wr_data = own_code;
          end
          state_d = DONE_OK;
        end
      end

      DONE_OK: begin
`ifdef FLIPSEQ_PROBE_EN
        legal     = probe_q;
        next_turn = !probe_q;
`else
        next_turn = 1'b1;
`endif
        flip_count = count_q;
        fcnt_d     = count_q;
        state_d    = IDLE;
      end

      DONE_BAD: begin
        illegal    = 1'b1;
        flip_count = 5'd0;
        fcnt_d     = 5'd0;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      row_q   <= 3'd0;
      col_q   <= 3'd0;
      white_q <= 1'b0;
      dir_q   <= 3'd0;
      run_q   <= 3'd0;
      count_q <= 5'd0;
      fcnt_q  <= 5'd0;
      cur_r_q <= 4'sd0;
      cur_c_q <= 4'sd0;
`ifdef FLIPSEQ_PROBE_EN
      probe_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      white_q <= white_d;
      dir_q   <= dir_d;
      run_q   <= run_d;
      count_q <= count_d;
      fcnt_q  <= fcnt_d;
      cur_r_q <= cur_r_d;
      cur_c_q <= cur_c_d;
`ifdef FLIPSEQ_PROBE_EN
      probe_q <= probe_d;
`endif
    end
  end

endmodule
